// File: rtl/xbar_cell_writer_if.sv
// Bus bundle for the crossbar cell writer: command in, pulse/verify drive to
// the array, result out, plus the success counter.
// slave  = writer's view, master = command source / array model view.
interface xbar_cell_writer_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) ();
    logic            cfg_valid;
    logic            cfg_ready;
    logic [3:0]      cfg_row;
    logic [3:0]      cfg_col;
    logic            cfg_val;
    logic [ROWS-1:0] wr_row_sel;
    logic [COLS-1:0] wr_col_sel;
    logic            wr_set;
    logic            wr_reset;
    logic            rd_en;
    logic            rd_val;
    logic            rsp_valid;
    logic            rsp_err;
    logic            rsp_ready;
    logic [7:0]      cells_ok;

    modport slave (
        input  cfg_valid, cfg_row, cfg_col, cfg_val, rd_val, rsp_ready,
        output cfg_ready, wr_row_sel, wr_col_sel, wr_set, wr_reset,
               rd_en, rsp_valid, rsp_err, cells_ok
    );

    modport master (
        output cfg_valid, cfg_row, cfg_col, cfg_val, rd_val, rsp_ready,
        input  cfg_ready, wr_row_sel, wr_col_sel, wr_set, wr_reset,
               rd_en, rsp_valid, rsp_err, cells_ok
    );
endinterface

// File: rtl/xbar_cell_writer.sv
// Crossbar cell writer: accepts one (row, col, value) command at a time,
// applies a SET or RESET pulse to the selected cell, verify-reads it and
// re-pulses on mismatch up to MAX_RETRY times before reporting a result.
// All array-facing strobes decode straight from the state register, so an
// asynchronous reset removes them without waiting for a clock edge.
module xbar_cell_writer #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int PULSE_CYC = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xbar_cell_writer_if.slave    bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PULSE  = 2'd1;
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYC - 1);
    localparam logic [3:0] RETRY_MAX  = 4'(MAX_RETRY);

    logic [1:0] state_q, state_d;
    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;
    logic       val_q, val_d;
    logic       err_q, err_d;
    logic [7:0] pulse_cnt_q, pulse_cnt_d;
    logic [3:0] retry_cnt_q, retry_cnt_d;
    logic [7:0] cells_ok_q, cells_ok_d;

    logic            cmd_in_range;
    logic            pulsing;
    logic [ROWS-1:0] row_hot;
    logic [COLS-1:0] col_hot;

    // Range check done on the live command so a bad address never reaches PULSE.
    assign cmd_in_range = ({1'b0, bus.cfg_row} < 5'(ROWS)) &&
                          ({1'b0, bus.cfg_col} < 5'(COLS));

    assign pulsing = (state_q == S_PULSE);

    // One-hot decode of the latched address, one comparator per line.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_dec
            assign row_hot[gi] = (row_q == 4'(gi));
        end
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col_dec
            assign col_hot[gi] = (col_q == 4'(gi));
        end
    endgenerate

    assign bus.cfg_ready  = (state_q == S_IDLE);
    assign bus.wr_row_sel = pulsing ? row_hot : '0;
    assign bus.wr_col_sel = pulsing ? col_hot : '0;
    assign bus.wr_set     = pulsing &  val_q;
    assign bus.wr_reset   = pulsing & ~val_q;
    assign bus.rd_en      = (state_q == S_VERIFY);
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_err    = (state_q == S_RESP) & err_q;
    assign bus.cells_ok   = cells_ok_q;

    // Next-state and datapath decisions for the write/verify/retry sequence.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        val_d       = val_q;
        err_d       = err_q;
        pulse_cnt_d = pulse_cnt_q;
        retry_cnt_d = retry_cnt_q;
        cells_ok_d  = cells_ok_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    row_d       = bus.cfg_row;
                    col_d       = bus.cfg_col;
                    val_d       = bus.cfg_val;
                    retry_cnt_d = 4'd0;
                    pulse_cnt_d = 8'd0;
                    if (cmd_in_range) begin
                        err_d   = 1'b0;
                        state_d = S_PULSE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_PULSE: begin
                if (pulse_cnt_q == PULSE_LAST) begin
                    pulse_cnt_d = 8'd0;
                    state_d     = S_VERIFY;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 8'd1;
                end
            end
            S_VERIFY: begin
                if (bus.rd_val == val_q) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                    if (cells_ok_q != 8'hFF) begin
                        cells_ok_d = cells_ok_q + 8'd1;
                    end
                end else if (retry_cnt_q < RETRY_MAX) begin
                    retry_cnt_d = retry_cnt_q + 4'd1;
                    state_d     = S_PULSE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            default: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and command registers; reset returns to IDLE with counters cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_q       <= 4'd0;
            col_q       <= 4'd0;
            val_q       <= 1'b0;
            err_q       <= 1'b0;
            pulse_cnt_q <= 8'd0;
            retry_cnt_q <= 4'd0;
            cells_ok_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            val_q       <= val_d;
            err_q       <= err_d;
            pulse_cnt_q <= pulse_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            cells_ok_q  <= cells_ok_d;
        end
    end

endmodule
